// File: rtl/fp_divider_if.sv
// fp_divider_if: start/done handshake and operand/result bundle for fp_divider.
//
// Handshake: the master raises start with a/b valid; the slave takes it
// on the first rising edge where busy=0 and start=1. A start seen while
// busy=1 is dropped, and the operands the slave holds stay as they are.
// When the result is written the slave pulses done for one cycle. final_quotient
// keeps that value until the next done. The master may raise start again in the
// done cycle.
//
// Signals:
//   start          master -> slave  request, sampled only while busy=0
//   a, b           master -> slave  dividend / divisor, IEEE-754 single
//   busy           slave  -> master high while an operation is in progress
//   done           slave  -> master one-cycle pulse when final_quotient updates
//   final_quotient slave  -> master result, held until the next done
//   dbg_state      slave  -> master FSM state (0=IDLE, 1=DIVIDE, 2=FINISH)
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] final_quotient;
    logic [1:0]  dbg_state;

    modport master (
        output start, a, b,
        input  busy, done, final_quotient, dbg_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, final_quotient, dbg_state
    );
endinterface

// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 single-precision divider, final_quotient = a / b.
// Restoring division of the 24-bit significands, one quotient bit per clock
// for 25 clocks. There are no denormals, results are truncated, and special
// operands are flushed to +inf or +0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_divider_if.slave (start, a, b, busy, done, final_quotient, dbg_state)
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    fp_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, next_state;

    logic        sign;
    logic [7:0]  ea, eb;
    logic        is_special;
    logic [31:0] special_res;
    logic [23:0] mb;
    logic [24:0] r;
    logic [24:0] q;
    logic [4:0]  count;
    logic [31:0] quotient;
    logic        done;

    // Operand classification, used only when a start is accepted.
    logic [7:0]  in_ea, in_eb;
    logic        in_special;
    logic [31:0] in_special_res;

    always_comb begin
        in_ea          = bus.a[30:23];
        in_eb          = bus.b[30:23];
        in_special     = 1'b0;
        in_special_res = 32'h0000_0000;
        if (in_ea == 8'hFF || in_eb == 8'h00) begin
            in_special     = 1'b1;
            in_special_res = 32'h7F80_0000;
        end else if (in_eb == 8'hFF || in_ea == 8'h00) begin
            in_special     = 1'b1;
            in_special_res = 32'h0000_0000;
        end
    end

    // One restoring step. r < 2*mb holds on every step, so after the
    // subtract r fits in 24 bits and the shift never loses the top bit.
    logic        q_bit;
    logic [24:0] r_sel;
    logic [24:0] r_next;

    always_comb begin
        q_bit  = (r >= {1'b0, mb});
        r_sel  = q_bit ? (r - {1'b0, mb}) : r;
        r_next = {r_sel[23:0], 1'b0};
    end

    // Normalisation and range handling for the FINISH edge.
    logic signed [9:0] e;
    logic [22:0]       mant;
    logic [31:0]       norm_res;

    always_comb begin
        if (q[24]) begin
            mant = q[23:1];
            e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        end else begin
            mant = q[22:0];
            e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
        end
        if (e >= 10'sd255)
            norm_res = {sign, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            norm_res = {sign, 31'h0};
        else
            norm_res = {sign, e[7:0], mant};
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = in_special ? FINISH : DIVIDE;
            DIVIDE:  if (count == 5'd24) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            ea          <= 8'h0;
            eb          <= 8'h0;
            is_special  <= 1'b0;
            special_res <= 32'h0;
            mb          <= 24'h0;
            r           <= 25'h0;
            q           <= 25'h0;
            count       <= 5'h0;
            quotient    <= 32'h0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign        <= bus.a[31] ^ bus.b[31];
                        ea          <= in_ea;
                        eb          <= in_eb;
                        is_special  <= in_special;
                        special_res <= in_special_res;
                        mb          <= {1'b1, bus.b[22:0]};
                        r           <= {2'b01, bus.a[22:0]};
                        q           <= 25'h0;
                        count       <= 5'h0;
                    end
                end
                DIVIDE: begin
                    r     <= r_next;
                    q     <= {q[23:0], q_bit};
                    count <= count + 5'd1;
                end
                FINISH: begin
                    quotient <= is_special ? special_res : norm_res;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (state != IDLE);
    assign bus.done           = done;
    assign bus.final_quotient = quotient;
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vector table for fp_divider plus hand-written
// handshake, back-to-back and asynchronous-reset sequences.
module tb_fp_divider;

    logic clk;
    logic rst_n;
    fp_divider_if bus ();

    fp_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Latency is the number of negedge samples after the start was driven.
    // The last sample is the one where done is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        while (!bus.done && lat < 60) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        res = bus.final_quotient;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        int lat, busy_cnt, k, done_seen;

        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        rst_n     = 1'b0;

        vecs.push_back('{"6div2",        32'h40C00000, 32'h40000000, 32'h40400000, 27});
        vecs.push_back('{"1div3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27});
        vecs.push_back('{"m1div3",       32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 27});
        vecs.push_back('{"1div1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 27});
        vecs.push_back('{"3div1p5",      32'h40400000, 32'h3FC00000, 32'h40000000, 27});
        vecs.push_back('{"m6divm2",      32'hC0C00000, 32'hC0000000, 32'h40400000, 27});
        vecs.push_back('{"spec_bzero",   32'h3F800000, 32'h00000000, 32'h7F800000, 2});
        vecs.push_back('{"spec_azero",   32'h00000000, 32'h40000000, 32'h00000000, 2});
        vecs.push_back('{"spec_binf",    32'h40000000, 32'h7F800000, 32'h00000000, 2});
        vecs.push_back('{"spec_inf_0",   32'h7F800000, 32'h00000000, 32'h7F800000, 2});
        vecs.push_back('{"spec_ninf",    32'hFF800000, 32'h7F800000, 32'h7F800000, 2});
        vecs.push_back('{"spec_nzero",   32'h80000000, 32'h3F800000, 32'h00000000, 2});
        vecs.push_back('{"ovf",          32'h7F000000, 32'h3E800000, 32'h7F800000, 27});
        vecs.push_back('{"ovf_neg",      32'hFF000000, 32'h3E800000, 32'hFF800000, 27});
        vecs.push_back('{"unf",          32'h00800000, 32'h40000000, 32'h00000000, 27});
        vecs.push_back('{"unf_neg",      32'h80800000, 32'h40000000, 32'h80000000, 27});
        vecs.push_back('{"e_min",        32'h00800000, 32'h3F800000, 32'h00800000, 27});
        vecs.push_back('{"e_max",        32'h7F000000, 32'h3F800000, 32'h7F000000, 27});

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_q",    bus.final_quotient, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat, busy_cnt);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy"}, busy_cnt, vecs[i].lat - 1);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
        end

        // start with new operands while busy is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 60) begin
            if (k == 4) begin
                bus.start = 1'b1;
                bus.a     = 32'h3F800000;
                bus.b     = 32'h00000000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check("ignore_lat", k, 27);
        check("ignore_res", bus.final_quotient, 32'h40400000);

        // Back-to-back: next start presented in the done cycle.
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", {31'h0, bus.busy}, 32'h1);
        check("b2b_hold", bus.final_quotient, 32'h40400000);
        k = 1;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("b2b_lat", k, 27);
        check("b2b_res", bus.final_quotient, 32'h3EAAAAAA);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'h0, bus.busy}, 32'h0);
        check("arst_done",  {31'h0, bus.done}, 32'h0);
        check("arst_q",     bus.final_quotient, 32'h0);
        check("arst_state", {30'h0, bus.dbg_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("arst_no_done", done_seen, 0);
        check("arst_hold_q", bus.final_quotient, 32'h0);

        run_op(32'h3F800000, 32'h40400000, res, lat, busy_cnt);
        check("post_rst_res", res, 32'h3EAAAAAA);
        check("post_rst_lat", lat, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
